// File: rtl/tmod_chan_ctrl.sv
// tmod_chan_ctrl: command-driven temperature channel controller.
// Holds per-channel samples, hi/lo thresholds and latched alarms. One command
// is in flight at a time: IDLE (accept) -> EXEC (one cycle) -> RESP (handshake).
module tmod_chan_ctrl #(
  parameter int NCHAN = 4,
  parameter int DW    = 8,
  parameter int CW    = $clog2(NCHAN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [CW-1:0]       cmd_chan,
  input  logic [DW-1:0]       cmd_opnd,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_data,
  output logic [1:0]          rsp_status,
  input  logic [NCHAN*DW-1:0] temp_in,
  input  logic [NCHAN-1:0]    temp_stb,
  output logic [NCHAN-1:0]    alarm,
  output logic                irq
);

  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_READ_TEMP   = 3'd1;
  localparam logic [2:0] OP_SET_HI      = 3'd2;
  localparam logic [2:0] OP_SET_LO      = 3'd3;
  localparam logic [2:0] OP_READ_ALARM  = 3'd4;
  localparam logic [2:0] OP_CLEAR_ALARM = 3'd5;
  localparam logic [2:0] OP_SET_HYST    = 3'd6;

  localparam logic [1:0] RS_OK        = 2'd0;
  localparam logic [1:0] RS_ERR_CHAN  = 2'd1;
  localparam logic [1:0] RS_ERR_OP    = 2'd2;
  localparam logic [1:0] RS_ERR_RANGE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;

  logic [2:0]        op_r;
  logic [CW-1:0]     chan_r;
  logic [DW-1:0]     opnd_r;

  logic [DW-1:0]     sample_r [NCHAN];
  logic [DW-1:0]     hi_r     [NCHAN];
  logic [DW-1:0]     lo_r     [NCHAN];
  logic [DW-1:0]     hyst_r;
  logic [NCHAN-1:0]  alarm_r;
  logic              irq_r;

  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic [DW-1:0]     rsp_data_r;
  logic [1:0]        rsp_status_r;

  logic [NCHAN-1:0]  chan_dec_s;
  logic              chan_ok_s;
  logic [DW-1:0]     sel_sample_s;
  logic [DW-1:0]     sel_hi_s;
  logic [DW-1:0]     sel_lo_s;
  logic              sel_set_s;
  logic              clr_ok_s;
  logic [NCHAN-1:0]  set_s;
  logic [NCHAN-1:0]  clr_s;

  logic              hi_we_s;
  logic              lo_we_s;
  logic              hyst_we_s;
  logic              clr_req_s;
  logic [DW-1:0]     data_nx_s;
  logic [1:0]        status_nx_s;

  // Out-of-window detection on incoming samples against the current thresholds.
  always_comb begin
    set_s = {NCHAN{1'b0}};
    for (int i = 0; i < NCHAN; i++) begin
      set_s[i] = temp_stb[i] &
                 ((temp_in[i*DW +: DW] > hi_r[i]) | (temp_in[i*DW +: DW] < lo_r[i]));
    end
  end

  // Decode the captured channel and mux out that channel's state.
  always_comb begin
    chan_dec_s   = {NCHAN{1'b0}};
    sel_sample_s = {DW{1'b0}};
    sel_hi_s     = {DW{1'b0}};
    sel_lo_s     = {DW{1'b0}};
    sel_set_s    = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (chan_r == CW'(i)) begin
        chan_dec_s[i] = 1'b1;
        sel_sample_s  = sample_r[i];
        sel_hi_s      = hi_r[i];
        sel_lo_s      = lo_r[i];
        sel_set_s     = set_s[i];
      end else begin
        chan_dec_s[i] = 1'b0;
      end
    end
    chan_ok_s = |chan_dec_s;
  end

  // Clear window lo+hyst <= sample <= hi-hyst, evaluated in DW+1 bits so
  // neither side can wrap (sample+hyst <= hi is the wrap-free form of the upper bound).
  assign clr_ok_s = (({1'b0, sel_lo_s} + {1'b0, hyst_r}) <= {1'b0, sel_sample_s}) &&
                    (({1'b0, sel_sample_s} + {1'b0, hyst_r}) <= {1'b0, sel_hi_s});

  // Execute the captured command: response payload and write enables.
  always_comb begin
    data_nx_s   = {DW{1'b0}};
    status_nx_s = RS_OK;
    hi_we_s     = 1'b0;
    lo_we_s     = 1'b0;
    hyst_we_s   = 1'b0;
    clr_req_s   = 1'b0;
    if (state_r == ST_EXEC) begin
      case (op_r)
        OP_NOP: begin
          data_nx_s = {DW{1'b0}};
        end
        OP_READ_TEMP: begin
          if (!chan_ok_s) status_nx_s = RS_ERR_CHAN;
          else            data_nx_s   = sel_sample_s;
        end
        OP_SET_HI: begin
          if (!chan_ok_s) begin
            status_nx_s = RS_ERR_CHAN;
          end else if (opnd_r < sel_lo_s) begin
            status_nx_s = RS_ERR_RANGE;
          end else begin
            hi_we_s   = 1'b1;
            data_nx_s = opnd_r;
          end
        end
        OP_SET_LO: begin
          if (!chan_ok_s) begin
            status_nx_s = RS_ERR_CHAN;
          end else if (opnd_r > sel_hi_s) begin
            status_nx_s = RS_ERR_RANGE;
          end else begin
            lo_we_s   = 1'b1;
            data_nx_s = opnd_r;
          end
        end
        OP_READ_ALARM: begin
          data_nx_s[NCHAN-1:0] = alarm_r;
        end
        OP_CLEAR_ALARM: begin
          // A same-cycle alarm set on this channel wins and is reported as OK.
          if (!chan_ok_s) begin
            status_nx_s = RS_ERR_CHAN;
          end else if (sel_set_s) begin
            status_nx_s = RS_OK;
          end else if (clr_ok_s) begin
            clr_req_s = 1'b1;
          end else begin
            status_nx_s = RS_ERR_RANGE;
          end
        end
        OP_SET_HYST: begin
          hyst_we_s = 1'b1;
          data_nx_s = opnd_r;
        end
        default: begin
          status_nx_s = RS_ERR_OP;
        end
      endcase
    end else begin
      status_nx_s = RS_OK;
    end
  end

  assign clr_s = chan_dec_s & {NCHAN{clr_req_s}};

  // Command FSM next-state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_nx_s = ST_EXEC;
        else           state_nx_s = ST_IDLE;
      end
      ST_EXEC: begin
        state_nx_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_RESP;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Command FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Capture the command fields on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= 3'd0;
      chan_r <= {CW{1'b0}};
      opnd_r <= {DW{1'b0}};
    end else if ((state_r == ST_IDLE) && cmd_valid) begin
      op_r   <= cmd_op;
      chan_r <= cmd_chan;
      opnd_r <= cmd_opnd;
    end
  end

  // Registered handshake flags and response payload loaded during EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= {DW{1'b0}};
      rsp_status_r <= RS_OK;
    end else begin
      cmd_ready_r <= (state_nx_s == ST_IDLE);
      rsp_valid_r <= (state_nx_s == ST_RESP);
      if (state_r == ST_EXEC) begin
        rsp_data_r   <= data_nx_s;
        rsp_status_r <= status_nx_s;
      end
    end
  end

  // Per-channel samples, thresholds and the shared hysteresis.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++) begin
        sample_r[i] <= {DW{1'b0}};
        hi_r[i]     <= {DW{1'b1}};
        lo_r[i]     <= {DW{1'b0}};
      end
      hyst_r <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (temp_stb[i])                sample_r[i] <= temp_in[i*DW +: DW];
        if (hi_we_s && chan_dec_s[i])   hi_r[i]     <= opnd_r;
        if (lo_we_s && chan_dec_s[i])   lo_r[i]     <= opnd_r;
      end
      if (hyst_we_s) hyst_r <= opnd_r;
    end
  end

  // Latched alarms (set has priority over clear) and the registered irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_r <= {NCHAN{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      alarm_r <= set_s | (alarm_r & ~clr_s);
      irq_r   <= |alarm_r;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_status = rsp_status_r;
  assign alarm      = alarm_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_tmod_chan_ctrl.sv
// Self-checking bench for tmod_chan_ctrl: directed scenarios plus random
// commands/strobes checked against a rule-level reference model.
module tb_tmod_chan_ctrl;

  localparam int NCHAN = 4;
  localparam int DW    = 8;
  localparam int CW    = 3;   // wide enough to present out-of-range channels

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [CW-1:0]       cmd_chan;
  logic [DW-1:0]       cmd_opnd;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
  logic [1:0]          rsp_status;
  logic [NCHAN*DW-1:0] temp_in;
  logic [NCHAN-1:0]    temp_stb;
  logic [NCHAN-1:0]    alarm;
  logic                irq;

  tmod_chan_ctrl #(.NCHAN(NCHAN), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chan(cmd_chan), .cmd_opnd(cmd_opnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .temp_in(temp_in), .temp_stb(temp_stb),
    .alarm(alarm), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_sample [NCHAN];
  int         m_hi     [NCHAN];
  int         m_lo     [NCHAN];
  int         m_hyst;
  logic [3:0] m_alarm;

  logic [7:0] last_data;
  logic [1:0] last_status;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCHAN; i++) begin
      m_sample[i] = 0;
      m_hi[i]     = 255;
      m_lo[i]     = 0;
    end
    m_hyst  = 0;
    m_alarm = 4'b0000;
  endtask

  // Effect of one executed command plus any strobes landing in the same cycle.
  task automatic model_exec(input logic [2:0] op, input logic [2:0] chan, input logic [7:0] opnd,
                            input logic [3:0] stb, input logic [31:0] tv,
                            output logic [7:0] ed, output logic [1:0] es);
    logic [3:0] setv;
    int c;
    int v;
    int s;
    c  = int'(chan);
    v  = int'(opnd);
    ed = 8'h00;
    es = 2'd0;
    for (int i = 0; i < NCHAN; i++) begin
      setv[i] = stb[i] && ((int'(tv[i*8 +: 8]) > m_hi[i]) || (int'(tv[i*8 +: 8]) < m_lo[i]));
    end
    case (op)
      3'd0: ed = 8'h00;
      3'd1: if (c >= NCHAN) es = 2'd1; else ed = 8'(m_sample[c]);
      3'd2: if (c >= NCHAN) es = 2'd1;
            else if (v < m_lo[c]) es = 2'd3;
            else begin m_hi[c] = v; ed = opnd; end
      3'd3: if (c >= NCHAN) es = 2'd1;
            else if (v > m_hi[c]) es = 2'd3;
            else begin m_lo[c] = v; ed = opnd; end
      3'd4: ed = {4'h0, m_alarm};
      3'd5: begin
        if (c >= NCHAN) es = 2'd1;
        else if (setv[c]) es = 2'd0;
        else begin
          s = m_sample[c];
          if ((m_lo[c] + m_hyst <= s) && (s <= m_hi[c] - m_hyst)) m_alarm[c] = 1'b0;
          else es = 2'd3;
        end
      end
      3'd6: begin m_hyst = v; ed = opnd; end
      default: es = 2'd2;
    endcase
    for (int i = 0; i < NCHAN; i++) begin
      if (stb[i]) begin
        if (setv[i]) m_alarm[i] = 1'b1;
        m_sample[i] = int'(tv[i*8 +: 8]);
      end
    end
  endtask

  // Issue one command; optional strobes during its EXEC cycle; hold rsp_ready low 'hold' cycles.
  task automatic send(input logic [2:0] op, input logic [2:0] chan, input logic [7:0] opnd,
                      input logic [3:0] stb, input logic [31:0] tv, input int hold);
    logic [7:0] ed;
    logic [1:0] es;
    int n;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_chan = chan; cmd_opnd = opnd;
    @(negedge clk);
    cmd_valid = 1'b0;
    temp_stb  = stb;
    temp_in   = tv;
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    model_exec(op, chan, opnd, stb, tv, ed, es);
    @(negedge clk);
    temp_stb = 4'b0000;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(ed));
    check("rsp_status", 32'(rsp_status), 32'(es));
    check("alarm_after_exec", 32'(alarm), 32'(m_alarm));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(ed));
      check("hold_status", 32'(rsp_status), 32'(es));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("irq", 32'(irq), 32'(|m_alarm));
    last_data   = ed;
    last_status = es;
  endtask

  // Strobe-only cycle: alarm updates immediately, irq follows one cycle later.
  task automatic strobe(input logic [3:0] stb, input logic [31:0] tv);
    logic [7:0] ed;
    logic [1:0] es;
    logic prev_irq;
    @(negedge clk);
    prev_irq = |m_alarm;
    temp_stb = stb;
    temp_in  = tv;
    model_exec(3'd0, 3'd0, 8'h00, stb, tv, ed, es);
    @(negedge clk);
    temp_stb = 4'b0000;
    check("strobe_alarm", 32'(alarm), 32'(m_alarm));
    check("strobe_irq_lag", 32'(irq), 32'(prev_irq));
    @(negedge clk);
    check("strobe_irq", 32'(irq), 32'(|m_alarm));
  endtask

  logic [2:0]  r_op;
  logic [2:0]  r_chan;
  logic [7:0]  r_opnd;
  logic [3:0]  r_stb;
  logic [31:0] r_tv;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_chan = 3'd0; cmd_opnd = 8'h00;
    rsp_ready = 1'b0; temp_in = 32'h0; temp_stb = 4'b0000;
    last_data = 8'h00; last_status = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // SET_HI ch2 0x50 with a five-cycle response stall
    send(3'd2, 3'd2, 8'h50, 4'b0000, 32'h0, 5);
    check("sethi_data", 32'(last_data), 32'h50);
    check("sethi_status", 32'(last_status), 32'd0);

    // Over-threshold sample raises alarm[2] and irq
    strobe(4'b0100, 32'h0060_0000);
    check("alarm_ch2", 32'(alarm), 32'h4);
    send(3'd4, 3'd0, 8'h00, 4'b0000, 32'h0, 0);
    check("read_alarm", 32'(last_data), 32'h04);

    // Hysteresis window for clearing
    send(3'd6, 3'd7, 8'h05, 4'b0000, 32'h0, 0);
    strobe(4'b0100, 32'h004C_0000);
    send(3'd5, 3'd2, 8'h00, 4'b0000, 32'h0, 0);
    check("clear_outside_status", 32'(last_status), 32'd3);
    check("clear_outside_alarm", 32'(alarm), 32'h4);
    strobe(4'b0100, 32'h004B_0000);
    send(3'd5, 3'd2, 8'h00, 4'b0000, 32'h0, 0);
    check("clear_inside_status", 32'(last_status), 32'd0);
    check("clear_inside_alarm", 32'(alarm), 32'h0);

    // Error cases
    send(3'd1, 3'd5, 8'h00, 4'b0000, 32'h0, 0);
    check("err_chan", 32'(last_status), 32'd1);
    send(3'd7, 3'd0, 8'h12, 4'b0000, 32'h0, 0);
    check("err_op", 32'(last_status), 32'd2);
    send(3'd3, 3'd2, 8'h60, 4'b0000, 32'h0, 0);
    check("setlo_range", 32'(last_status), 32'd3);
    send(3'd3, 3'd2, 8'h4B, 4'b0000, 32'h0, 0);
    check("setlo_ok", 32'(last_status), 32'd0);

    // Alarm set in the same cycle as CLEAR_ALARM on that channel wins
    send(3'd2, 3'd1, 8'hFA, 4'b0000, 32'h0, 0);
    send(3'd5, 3'd1, 8'h00, 4'b0010, 32'h0000_FF00, 0);
    check("setwins_status", 32'(last_status), 32'd0);
    check("setwins_alarm1", 32'(alarm[1]), 32'd1);

    // Random commands with occasional same-cycle strobes
    for (int k = 0; k < 80; k++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_chan = 3'($urandom_range(0, 5));
      r_opnd = 8'($urandom);
      r_stb  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      r_tv   = $urandom;
      send(r_op, r_chan, r_opnd, r_stb, r_tv, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) strobe(4'($urandom), $urandom);
    end

    // Reset while a response is pending
    strobe(4'b0001, 32'h0000_0033);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_chan = 3'd0; cmd_opnd = 8'h10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd1);
    check("async_rst_data", 32'(rsp_data), 32'd0);
    check("async_rst_alarm", 32'(alarm), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send(3'd1, 3'd0, 8'h00, 4'b0000, 32'h0, 0);
    check("rst_read_temp", 32'(last_data), 32'h00);
    send(3'd3, 3'd0, 8'hFF, 4'b0000, 32'h0, 0);
    check("rst_hi_setlo_ff", 32'(last_status), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmod_chan_ctrl.md
TMOD_CHAN_CTRL -- requirements
Module: tmod_chan_ctrl

Interface
REQ-001 Parameter NCHAN, default 4: number of temperature channels, 2..DW.
REQ-002 Parameter DW, default 8: temperature, threshold and operand width in bits, unsigned.
REQ-003 Parameter CW, default $clog2(NCHAN): channel index width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  master command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_op  input  3  opcode, encoded per REQ-015.
REQ-009 cmd_chan  input  CW  target channel.
REQ-010 cmd_opnd  input  DW  operand.
REQ-011 rsp_valid / rsp_ready  output / input  1 each  response handshake.
REQ-012 rsp_data  output DW; rsp_status  output 2 (0 OK, 1 ERR_CHAN, 2 ERR_OP, 3 ERR_RANGE).
REQ-013 temp_in  input  NCHAN*DW  channel i on bits [i*DW +: DW]; temp_stb  input  NCHAN  per-channel sample strobe.
REQ-014 alarm  output  NCHAN  latched per-channel alarm; irq  output  1  registered OR of alarm.

Function
REQ-015 Opcodes: 0 NOP, 1 READ_TEMP, 2 SET_HI, 3 SET_LO, 4 READ_ALARM, 5 CLEAR_ALARM, 6 SET_HYST, 7 reserved.
REQ-016 FSM states IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-017 Command accepted on edge where cmd_valid & cmd_ready; op/chan/opnd captured; IDLE->EXEC.
REQ-018 EXEC lasts exactly one cycle, performs the op, loads rsp_data/rsp_status; EXEC->RESP.
REQ-019 In RESP rsp_valid = 1, rsp_data/rsp_status stable; on rsp_valid & rsp_ready -> IDLE; no timeout.
REQ-020 Latency: rsp_valid rises on 2nd rising edge after accept; min 3 cycles between accepts.
REQ-021 cmd_chan >= NCHAN on ops 1,2,3,5: no state change, status ERR_CHAN, data 0.
REQ-022 Opcode 7: status ERR_OP, data 0, no state change.
REQ-023 NOP: status OK, data 0. READ_TEMP: data = sample[chan]. READ_ALARM: data = alarm zero-extended to DW.
REQ-024 SET_HI: opnd < lo[chan] -> ERR_RANGE, no write; else hi[chan] = opnd, OK, data = opnd. SET_LO symmetric (opnd > hi[chan] -> ERR_RANGE).
REQ-025 SET_HYST: hyst = opnd, OK, data = opnd; chan ignored.
REQ-026 temp_stb[i] high: sample[i] <= temp_in slice i; any subset of channels may strobe same cycle.
REQ-027 Alarm set: on strobe cycle, if slice > hi[i] or slice < lo[i], alarm[i] <= 1 (compare uses incoming value).
REQ-028 CLEAR_ALARM: clears alarm[chan] only if lo+hyst <= sample[chan] <= hi-hyst, sums/differences in DW+1 bits (no wrap); otherwise alarm kept, status ERR_RANGE.
REQ-029 Same-cycle alarm set (REQ-027) and CLEAR_ALARM on same channel: set wins, status OK.
REQ-030 Threshold writes do not re-evaluate alarms; evaluation happens only on strobe.
REQ-031 irq = registered OR of alarm, one cycle after alarm changes.

Reset
REQ-032 On reset assertion, immediately: FSM IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_status 0, alarm 0, irq 0.
REQ-033 Reset values: sample[i] = 0, hi[i] = all ones, lo[i] = 0, hyst = 0.
REQ-034 Reset during EXEC/RESP discards pending response and any incomplete write.

Verification
REQ-035 NCHAN=4, DW=8: SET_HI ch2 opnd 0x50 -> after 2 edges rsp_valid, OK, data 0x50; hold rsp_ready 0 five cycles -> outputs stable.
REQ-036 temp_stb[2] with slice 0x60 -> alarm = 0b0100, irq 1 next cycle; READ_ALARM -> data 0x04.
REQ-037 hyst 0x05, hi 0x50; strobe ch2 0x4C, CLEAR_ALARM ch2 -> ERR_RANGE, alarm kept; strobe 0x4B, clear -> OK, alarm 0.
REQ-038 cmd_chan 5 READ_TEMP -> ERR_CHAN; op 7 -> ERR_OP; SET_LO 0x60 with hi 0x50 -> ERR_RANGE, lo unchanged.
REQ-039 strobe ch1 0xFF (hi 0xFA) in same cycle as CLEAR_ALARM ch1 EXEC -> alarm[1] remains 1.
REQ-040 Reset asserted in RESP -> rsp_valid 0 without clock edge; READ_TEMP afterwards returns 0; hi reads back via SET_LO 0xFF -> OK.
